// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the MEM-stage load/store port.
// Accepts one valid/ready request at a time, commits it after LATENCY cycles,
// then holds the response until the requester takes it.
// Word-addressed array with byte-lane writes; misaligned or out-of-range
// accesses are reported through rsp_err_o and never touch the array.
// Optional macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          handshake;
    logic          acc_err;
    logic [AW-1:0] word_idx;

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign commit      = (state == WAIT) && (cnt == 4'd0) && !rst_i;
    assign handshake   = (state == RESP) && rsp_ready_i;
    assign word_idx    = addr_q[AW+1:2];
    assign acc_err     = (addr_q[1:0] != 2'b00) ||
                         ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));

    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = busy_q;

    // State register; busy is registered from the next state so it tracks it exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
        end
    end

    // Next-state logic: every request waits in WAIT so the response lands LATENCY edges after acceptance.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = WAIT;
            WAIT:    if (cnt == 4'd0) next_state = RESP;
            RESP:    if (rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latency counter and request capture on acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt     <= 4'(LATENCY - 1);
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers: loaded on the commit edge, cleared on handshake or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= acc_err;
            rdata_q <= (!acc_err && !write_q) ? mem[word_idx] : 32'd0;
        end else if (handshake) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    // Array byte-lane write on the commit edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (commit && write_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating access statistics, counted when the response is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_o  <= 16'd0;
            wr_cnt_o  <= 16'd0;
            err_cnt_o <= 16'd0;
        end else if (handshake) begin
            if (err_q) begin
                if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
            end else if (write_q) begin
                if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
            end else begin
                if (rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
